// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial front end for the serial sequence detector
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    // A zero-length gap still needs a legal one-bit counter; it simply never leaves 0.
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [BW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;
    logic             accept;
    logic             last_bit;
    logic             gap_end;

    assign last_bit = (state == S_SHIFT) && (bit_cnt == BIT_LAST);
    assign gap_end  = (state == S_GAP) && (gap_cnt == GAP_LAST);
    assign accept   = din_valid && din_ready;

    // Ready decode: idle, last bit when streaming without gap, or last gap cycle; never in reset.
    always_comb begin
        din_ready = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE:  din_ready = 1'b1;
                S_SHIFT: din_ready = last_bit && (GAP == 0);
                S_GAP:   din_ready = gap_end;
                default: din_ready = 1'b0;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a new word always restarts SHIFT, otherwise fall to GAP or IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (last_bit) begin
                    if (accept)       state_nxt = S_SHIFT;
                    else if (GAP > 0) state_nxt = S_GAP;
                    else              state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_end) state_nxt = accept ? S_SHIFT : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Shift register and counters; a load takes precedence over shifting the final bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg    <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else if (accept) begin
            sreg    <= din;
            bit_cnt <= '0;
        end else if (state == S_SHIFT) begin
            if (MSB_FIRST != 0) sreg <= {sreg[WIDTH-2:0], 1'b0};
            else                sreg <= {1'b0, sreg[WIDTH-1:1]};
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            gap_cnt <= '0;
        end else if (state == S_GAP) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    // Outputs decode only registered state, so din never reaches dout combinationally.
    assign dout       = (state == S_SHIFT) && ((MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0]);
    assign dout_valid = (state == S_SHIFT);
    assign busy       = (state != S_IDLE);
    assign done       = last_bit;

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the serial sequence-detector FSM. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock on `dout`. `dout` connects directly to the detector's `din`. An optional idle gap separates words; back-to-back streaming is supported when the gap is zero.

## Interface
- `WIDTH`, default 8: bits per word; legal range WIDTH ≥ 2.
- `MSB_FIRST`, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- `GAP`, default 0: number of idle cycles inserted after each word; legal range GAP ≥ 0.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `din`, input, WIDTH: parallel word to serialize.
- `din_valid`, input, 1: `din` holds a word to send.
- `din_ready`, output, 1: block will capture `din` at this edge if `din_valid` is high.
- `dout`, output, 1: serial bit; feeds the detector's `din`.
- `dout_valid`, output, 1: `dout` carries a word bit this cycle.
- `busy`, output, 1: state is not IDLE.
- `done`, output, 1: one-cycle pulse coincident with the last bit of a word.

## Operation
- States:
  - IDLE: nothing transmitting.
  - SHIFT: word bits on `dout`.
  - GAP: idle spacing after a word.
- Counters:
  - `bit_cnt`: width $clog2(WIDTH); counts 0..WIDTH-1 in SHIFT.
  - `gap_cnt`: width $clog2(GAP+1); counts 0..GAP-1 in GAP.
- Acceptance occurs when `din_valid && din_ready` at a rising edge. On acceptance:
  - `din` is loaded into the shift register.
  - `bit_cnt` is set to 0.
  - The next state is SHIFT.
- `din_ready` is combinational and is high only when `rst` is low and one of the following holds:
  - state is IDLE;
  - state is SHIFT, `bit_cnt` == WIDTH-1, and GAP == 0;
  - state is GAP and `gap_cnt` == GAP-1.
- SHIFT behaviour:
  - `dout` is the shift register's MSB or LSB, selected by MSB_FIRST.
  - `dout_valid` = 1.
  - The register shifts and `bit_cnt` increments each cycle.
- At `bit_cnt` == WIDTH-1:
  - `done` = 1.
  - Next state: SHIFT (reload) if accepted; otherwise GAP if GAP > 0; otherwise IDLE.
- GAP behaviour:
  - `dout` = 0 and `dout_valid` = 0.
  - Exits after GAP cycles: to SHIFT if accepted in the last GAP cycle, else to IDLE.
- IDLE behaviour: `dout` = 0, `dout_valid` = 0, `busy` = 0.
- Handshake rules:
  - `din` and `din_valid` are ignored when `din_ready` is low.
  - A word is never dropped once accepted, except by reset.
- Reset:
  - Any cycle with `rst` high forces the following at the next edge: state IDLE, shift register 0, both counters 0, `dout` 0, `dout_valid` 0, `done` 0, `busy` 0.
  - `din_ready` is 0 while `rst` is high.
  - Reset mid-word aborts the word: remaining bits are not sent and no `done` is issued.
  - `rst` takes priority over simultaneous acceptance.

## Timing
- Word accepted at the edge ending cycle k:
  - Bit 0 of the transmit order appears on `dout` in cycle k+1.
  - The last bit appears in cycle k+WIDTH, with `done` high in that cycle only.
- `dout`, `dout_valid`, `done` and `busy` are registered (state-decoded from registered state). No combinational path from `din` to `dout`.
- GAP = 0 with continuous `din_valid`: `dout_valid` stays high indefinitely, one word every WIDTH cycles with no bubble.
- GAP = G > 0:
  - `dout_valid` is low for exactly G cycles between consecutive words when the next word is valid in time.
  - A word arriving later is accepted in IDLE; its first bit follows one cycle after acceptance.
- First acceptance is possible in the first cycle after `rst` deasserts.

## Test plan
- Single word, MSB first:
  - Stimulus: WIDTH=8, MSB_FIRST=1, GAP=0; accept `din` = 8'hB6 at edge k.
  - Response: `dout` = 1,0,1,1,0,1,1,0 over cycles k+1..k+8; `done` high only in k+8; IDLE with `busy` = 0 in k+9.
- LSB first:
  - Stimulus: MSB_FIRST=0; send 8'h01.
  - Response: `dout` = 1 then seven 0s; `done` on the 8th bit.
- Back-to-back streaming:
  - Stimulus: GAP=0; `din_valid` held high with 8'hFF then 8'h00.
  - Response: `din_ready` high in cycle k+8; `dout_valid` high for 16 consecutive cycles; `dout` shows eight 1s then eight 0s; two `done` pulses 8 cycles apart.
- Gap insertion:
  - Stimulus: GAP=3; two words queued.
  - Response: `dout_valid` low for exactly 3 cycles between words; `din_ready` high only in the 3rd GAP cycle.
- Reset mid-word:
  - Stimulus: send 8'hFF; assert `rst` for one cycle during the 4th bit.
  - Response: `dout` = 0 and `dout_valid` = 0 from the next cycle; no `done`; `din_ready` = 0 during `rst` and = 1 the cycle after.
- Chain with detector:
  - Stimulus: serializer `dout` drives the detector `din`; send 8'hE0, MSB first.
  - Response: detector `dout` pulses exactly once, in the cycle the third 1 is presented.
